// File: rtl/vram_fetch_server.sv
// vram_fetch_server
// Memory-side responder for the video controller's VRAM fetch port. On each
// fetch_stb it reads two 16-bit values, each at an arbitrary byte address,
// from word-wide memory through a single-outstanding req/ack handshake. It
// then commits both values to vram_dout1/vram_dout2 atomically. Odd byte
// addresses are split into two word reads. A ce_24m-driven budget flags late
// fetches. A fetch that is aborted by a new strobe is also flagged.
//
// Ports
//   clk_sys      in   master clock
//   reset        in   asynchronous active-high reset
//   ce_24m       in   24 MHz clock enable, ticks the fetch budget
//   fetch_stb    in   one-cycle strobe: latch vram_addr1/2, start a fetch
//   vram_addr1   in   [18:0] byte address of first value
//   vram_addr2   in   [18:0] byte address of second value
//   vram_dout1   out  [15:0] {mem[addr1+1], mem[addr1]}
//   vram_dout2   out  [15:0] {mem[addr2+1], mem[addr2]}
//   busy         out  fetch in progress (including orphan drain)
//   underrun     out  one-cycle pulse: budget expired or fetch aborted
//   mem_rd       out  word read request
//   mem_addr     out  [17:0] word address
//   mem_ack      in   one-cycle pulse: mem_din valid, request retired
//   mem_din      in   [15:0] read word, [7:0] = even byte

module vram_fetch_server #(
    parameter int unsigned FETCH_BUDGET = 16
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ce_24m,
    input  logic        fetch_stb,
    input  logic [18:0] vram_addr1,
    input  logic [18:0] vram_addr2,
    output logic [15:0] vram_dout1,
    output logic [15:0] vram_dout2,
    output logic        busy,
    output logic        underrun,
    output logic        mem_rd,
    output logic [17:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_din
);

    localparam int unsigned BW = (FETCH_BUDGET < 1) ? 1 : $clog2(FETCH_BUDGET + 1);

    typedef enum logic [2:0] {
        IDLE,
        RD1A,
        RD1B,
        RD2A,
        RD2B,
        COMMIT,
        DRAIN
    } state_t;

    state_t      state_q, state_d;
    logic [18:0] addr1_q, addr1_d;
    logic [18:0] addr2_q, addr2_d;
    logic [15:0] res1_q, res1_d;
    logic [15:0] res2_q, res2_d;
    logic [15:0] dout1_q, dout1_d;
    logic [15:0] dout2_q, dout2_d;
    logic        busy_q, busy_d;
    logic        underrun_q, underrun_d;
    logic        ur_done_q, ur_done_d;
    logic        mem_rd_q, mem_rd_d;
    logic [17:0] mem_addr_q, mem_addr_d;
    logic [BW-1:0] budget_q, budget_d;

    logic ack_ok;
    assign ack_ok = mem_rd_q & mem_ack;

    always_comb begin
        state_d    = state_q;
        addr1_d    = addr1_q;
        addr2_d    = addr2_q;
        res1_d     = res1_q;
        res2_d     = res2_q;
        dout1_d    = dout1_q;
        dout2_d    = dout2_q;
        mem_rd_d   = mem_rd_q;
        mem_addr_d = mem_addr_q;
        underrun_d = 1'b0;
        ur_done_d  = ur_done_q;
        budget_d   = budget_q;

        if (busy_q && ce_24m && (budget_q != '0)) begin
            budget_d = budget_q - 1'b1;
        end

        // Budget expiry is reported once per fetch; a fetch already in
        // COMMIT is complete and cannot underrun.
        if (busy_q && !ur_done_q && (state_q != COMMIT) && (budget_d == '0)) begin
            underrun_d = 1'b1;
            ur_done_d  = 1'b1;
        end

        // Each read state raises mem_rd one cycle after entry, then holds
        // request and address until the ack retires it.
        case (state_q)
            RD1A: begin
                if (!mem_rd_q) begin
                    mem_rd_d   = 1'b1;
                    mem_addr_d = addr1_q[18:1];
                end else if (mem_ack) begin
                    mem_rd_d = 1'b0;
                    res1_d   = mem_din;
                    state_d  = addr1_q[0] ? RD1B : RD2A;
                end
            end
            RD1B: begin
                if (!mem_rd_q) begin
                    mem_rd_d   = 1'b1;
                    mem_addr_d = addr1_q[18:1] + 18'd1;
                end else if (mem_ack) begin
                    mem_rd_d = 1'b0;
                    res1_d   = {mem_din[7:0], res1_q[15:8]};
                    state_d  = RD2A;
                end
            end
            RD2A: begin
                if (!mem_rd_q) begin
                    mem_rd_d   = 1'b1;
                    mem_addr_d = addr2_q[18:1];
                end else if (mem_ack) begin
                    mem_rd_d = 1'b0;
                    res2_d   = mem_din;
                    state_d  = addr2_q[0] ? RD2B : COMMIT;
                end
            end
            RD2B: begin
                if (!mem_rd_q) begin
                    mem_rd_d   = 1'b1;
                    mem_addr_d = addr2_q[18:1] + 18'd1;
                end else if (mem_ack) begin
                    mem_rd_d = 1'b0;
                    res2_d   = {mem_din[7:0], res2_q[15:8]};
                    state_d  = COMMIT;
                end
            end
            COMMIT: begin
                dout1_d = res1_q;
                dout2_d = res2_q;
                state_d = IDLE;
            end
            DRAIN: begin
                // Orphaned request from an aborted fetch: data is discarded.
                if (ack_ok) begin
                    mem_rd_d = 1'b0;
                    state_d  = RD1A;
                end
            end
            default: ;
        endcase

        // A new strobe overrides whatever the FSM decided this cycle. A
        // request still outstanding after this edge must be drained first.
        // An ack arriving now retires it, so the new fetch starts directly.
        if (fetch_stb) begin
            addr1_d   = vram_addr1;
            addr2_d   = vram_addr2;
            budget_d  = BW'(FETCH_BUDGET);
            ur_done_d = 1'b0;
            dout1_d   = dout1_q;
            dout2_d   = dout2_q;
            if (busy_q) begin
                underrun_d = 1'b1;
            end
            if (ack_ok || !mem_rd_q) begin
                mem_rd_d   = 1'b0;
                mem_addr_d = mem_addr_q;
                state_d    = RD1A;
            end else begin
                mem_rd_d   = 1'b1;
                mem_addr_d = mem_addr_q;
                state_d    = DRAIN;
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            addr1_q    <= '0;
            addr2_q    <= '0;
            res1_q     <= '0;
            res2_q     <= '0;
            dout1_q    <= '0;
            dout2_q    <= '0;
            busy_q     <= 1'b0;
            underrun_q <= 1'b0;
            ur_done_q  <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            budget_q   <= '0;
        end else begin
            state_q    <= state_d;
            addr1_q    <= addr1_d;
            addr2_q    <= addr2_d;
            res1_q     <= res1_d;
            res2_q     <= res2_d;
            dout1_q    <= dout1_d;
            dout2_q    <= dout2_d;
            busy_q     <= busy_d;
            underrun_q <= underrun_d;
            ur_done_q  <= ur_done_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            budget_q   <= budget_d;
        end
    end

    assign vram_dout1 = dout1_q;
    assign vram_dout2 = dout2_q;
    assign busy       = busy_q;
    assign underrun   = underrun_q;
    assign mem_rd     = mem_rd_q;
    assign mem_addr   = mem_addr_q;

endmodule

// File: tb/tb_vram_fetch_server.sv
// tb_vram_fetch_server
// Randomized self-checking bench for vram_fetch_server. It contains a
// byte-addressed reference memory, a latency-programmable responder and a
// handshake monitor.

module tb_vram_fetch_server;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce_24m;
    logic        fetch_stb;
    logic [18:0] vram_addr1;
    logic [18:0] vram_addr2;
    logic [15:0] vram_dout1;
    logic [15:0] vram_dout2;
    logic        busy;
    logic        underrun;
    logic        mem_rd;
    logic [17:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_din;

    always #5 clk = ~clk;

    vram_fetch_server #(.FETCH_BUDGET(16)) dut (
        .clk_sys    (clk),
        .reset      (reset),
        .ce_24m     (ce_24m),
        .fetch_stb  (fetch_stb),
        .vram_addr1 (vram_addr1),
        .vram_addr2 (vram_addr2),
        .vram_dout1 (vram_dout1),
        .vram_dout2 (vram_dout2),
        .busy       (busy),
        .underrun   (underrun),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_din    (mem_din)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference memory: hashed contents with per-test overrides.
    logic [15:0] ov [int unsigned];

    function automatic logic [15:0] memw(input logic [17:0] w);
        int unsigned k;
        logic [31:0] h;
        k = 32'(w);
        if (ov.exists(k)) return ov[k];
        h = k * 32'h9E37_79B1;
        return h[31:16] ^ h[15:0];
    endfunction

    function automatic logic [7:0] byte_at(input logic [18:0] b);
        logic [15:0] w;
        w = memw(b[18:1]);
        return b[0] ? w[15:8] : w[7:0];
    endfunction

    function automatic logic [15:0] exp_val(input logic [18:0] a);
        logic [18:0] nb;
        nb = a + 19'd1;
        return {byte_at(nb), byte_at(a)};
    endfunction

    logic [17:0] exp_q[$];
    logic [17:0] log_q[$];

    // Every word holding a byte of the value, in address order.
    task automatic add_reads(input logic [18:0] a);
        logic [18:0] nb;
        nb = a + 19'd1;
        exp_q.push_back(a[18:1]);
        if (nb[18:1] != a[18:1]) exp_q.push_back(nb[18:1]);
    endtask

    int unsigned lat = 2;
    bit          spur_en = 1'b0;
    int unsigned ur_cnt = 0;
    int unsigned commit_cnt = 0;

    // Memory responder and ce_24m generator (ce every 4th clk_sys).
    initial begin : responder
        int unsigned cnt;
        int unsigned tick;
        cnt = 0;
        tick = 0;
        mem_ack = 1'b0;
        mem_din = '0;
        ce_24m = 1'b0;
        forever begin
            @(negedge clk);
            tick++;
            ce_24m = (tick % 4 == 0);
            mem_ack = 1'b0;
            if (reset) begin
                cnt = 0;
            end else if (mem_rd) begin
                if (cnt >= lat) begin
                    mem_ack = 1'b1;
                    mem_din = memw(mem_addr);
                    log_q.push_back(mem_addr);
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
                if (spur_en && $urandom_range(0, 3) == 0) begin
                    mem_ack = 1'b1;
                    mem_din = 16'($urandom);
                end
            end
        end
    end

    // Handshake monitor, underrun and commit counters.
    initial begin : monitor
        logic        prev_rd;
        logic        prev_ack;
        logic        prev_busy;
        logic [17:0] prev_addr;
        prev_rd = 1'b0;
        prev_ack = 1'b0;
        prev_busy = 1'b0;
        prev_addr = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!reset) begin
                if (prev_rd && !prev_ack)
                    check_eq("req_hold", 32'({mem_rd, mem_addr}), 32'({1'b1, prev_addr}));
                if (prev_rd && prev_ack)
                    check_eq("req_drop", 32'(mem_rd), 32'(0));
                if (underrun) ur_cnt++;
                if (prev_busy && !busy) commit_cnt++;
            end
            prev_rd = mem_rd;
            prev_ack = mem_ack;
            prev_addr = mem_addr;
            prev_busy = busy;
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic strobe(input logic [18:0] a1, input logic [18:0] a2);
        vram_addr1 = a1;
        vram_addr2 = a2;
        fetch_stb = 1'b1;
        @(negedge clk);
        fetch_stb = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int unsigned n;
        n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (busy) check_eq({tag, "_timeout"}, 32'(busy), 32'(0));
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_req(input string tag);
        int unsigned n;
        n = 0;
        while (!mem_rd && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!mem_rd) check_eq({tag, "_noreq"}, 32'(mem_rd), 32'(1));
    endtask

    task automatic clear_obs();
        exp_q.delete();
        log_q.delete();
        ur_cnt = 0;
        commit_cnt = 0;
    endtask

    task automatic check_results(input string tag, input logic [18:0] a1, input logic [18:0] a2,
                                 input int unsigned exp_ur);
        check_eq({tag, "_nreads"}, 32'(log_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            check_eq($sformatf("%s_rd%0d", tag, i), 32'(log_q[i]), 32'(exp_q[i]));
        check_eq({tag, "_dout1"}, 32'(vram_dout1), 32'(exp_val(a1)));
        check_eq({tag, "_dout2"}, 32'(vram_dout2), 32'(exp_val(a2)));
        check_eq({tag, "_underrun"}, ur_cnt, exp_ur);
        check_eq({tag, "_commits"}, commit_cnt, 32'(1));
    endtask

    task automatic run_fetch(input string tag, input logic [18:0] a1, input logic [18:0] a2,
                             input int unsigned exp_ur);
        clear_obs();
        add_reads(a1);
        add_reads(a2);
        @(negedge clk);
        strobe(a1, a2);
        check_eq({tag, "_busy"}, 32'(busy), 32'(1));
        wait_idle(tag);
        check_results(tag, a1, a2, exp_ur);
    endtask

    // Second strobe while the first request of a fetch is outstanding,
    // either before its ack (drain path) or coincident with it.
    task automatic run_abort(input string tag, input logic [18:0] o1, input logic [18:0] o2,
                             input logic [18:0] n1, input logic [18:0] n2, input bit coincide);
        clear_obs();
        exp_q.push_back(o1[18:1]);
        add_reads(n1);
        add_reads(n2);
        @(negedge clk);
        strobe(o1, o2);
        wait_req(tag);
        if (coincide) repeat (lat) @(negedge clk);
        strobe(n1, n2);
        check_eq({tag, "_busy"}, 32'(busy), 32'(1));
        wait_idle(tag);
        check_results(tag, n1, n2, 1);
    endtask

    initial begin : stimulus
        logic [18:0] a1;
        logic [18:0] a2;
        reset = 1'b1;
        fetch_stb = 1'b0;
        vram_addr1 = '0;
        vram_addr2 = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_dout1", 32'(vram_dout1), 32'(0));
        check_eq("rst_dout2", 32'(vram_dout2), 32'(0));
        check_eq("rst_busy", 32'(busy), 32'(0));
        check_eq("rst_underrun", 32'(underrun), 32'(0));
        check_eq("rst_mem_rd", 32'(mem_rd), 32'(0));
        check_eq("rst_mem_addr", 32'(mem_addr), 32'(0));
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Aligned pair.
        ov[32'h8] = 16'hBEEF;
        lat = 2;
        run_fetch("aligned", 19'h00010, 19'h01800, 0);
        check_eq("aligned_beef", 32'(vram_dout1), 32'h0000_BEEF);

        // Odd addr1 split across words 0x8 and 0x9.
        ov[32'h8] = 16'h1234;
        ov[32'h9] = 16'hABCD;
        run_fetch("odd", 19'h00011, 19'h02468, 0);
        check_eq("odd_cd12", 32'(vram_dout1), 32'h0000_CD12);

        // Last odd byte wraps to word 0.
        ov[32'h3FFFF] = 16'h5AC3;
        ov[32'h0] = 16'h9617;
        run_fetch("wrap", 19'h7FFFF, 19'h00040, 0);
        check_eq("wrap_val", 32'(vram_dout1), 32'h0000_175A);

        // Slow memory, both odd: budget expires, fetch commits late.
        lat = 20;
        a1 = 19'($urandom) | 19'd1;
        a2 = 19'($urandom) | 19'd1;
        run_fetch("late", a1, a2, 1);

        lat = 5;
        run_abort("drain", 19'($urandom), 19'($urandom), 19'($urandom), 19'($urandom), 1'b0);
        run_abort("coinc", 19'($urandom), 19'($urandom), 19'($urandom), 19'($urandom), 1'b1);

        // Reset while a request is outstanding.
        @(negedge clk);
        strobe(19'($urandom), 19'($urandom));
        wait_req("rstmid");
        reset = 1'b1;
        #1;
        check_eq("rstmid_dout1", 32'(vram_dout1), 32'(0));
        check_eq("rstmid_dout2", 32'(vram_dout2), 32'(0));
        check_eq("rstmid_busy", 32'(busy), 32'(0));
        check_eq("rstmid_mem_rd", 32'(mem_rd), 32'(0));
        check_eq("rstmid_mem_addr", 32'(mem_addr), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        lat = 2;
        run_fetch("after_rst", 19'($urandom), 19'($urandom), 0);

        // Random traffic with ignored stray acks.
        spur_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            lat = $urandom_range(0, 4);
            run_fetch($sformatf("rnd%0d", i), 19'($urandom), 19'($urandom), 0);
        end
        spur_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
